// File: rtl/if_stage_pipe_reg.sv
// IF/ID stage register: carries {pc, instruction} from fetch to decode over valid/ready.
// Define IF_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module if_stage_pipe_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               freeze,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instruction
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               accept_s;
  logic               release_s;

`ifdef IF_STAGE_SKID_EN
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               in_ready_q, in_ready_d;

  assign in_ready = in_ready_q && !freeze;
`else
  // Single entry: a slot frees up only when decode takes the head in the same cycle.
  assign in_ready = !freeze && ((state_q == ST_EMPTY) || out_ready);
`endif

  assign out_valid   = (state_q != ST_EMPTY) && !freeze;
  assign accept_s    = in_valid && in_ready;
  assign release_s   = out_valid && out_ready;
  assign pc          = (state_q != ST_EMPTY) ? main_pc_q : {PC_W{1'b0}};
  assign instruction = (state_q != ST_EMPTY) ? main_instr_q : NOP_INSTR;

  // Next-state and data-load decisions: flush beats freeze beats normal flow.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
`ifdef IF_STAGE_SKID_EN
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (freeze) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d      = ST_ONE;
            main_pc_d    = pc_in;
            main_instr_d = instruction_in;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && release_s) begin
            state_d      = ST_ONE;
            main_pc_d    = pc_in;
            main_instr_d = instruction_in;
          end else if (accept_s) begin
`ifdef IF_STAGE_SKID_EN
            state_d      = ST_TWO;
            skid_pc_d    = pc_in;
            skid_instr_d = instruction_in;
`else
            state_d      = ST_ONE;
`endif
          end else if (release_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
`ifdef IF_STAGE_SKID_EN
        ST_TWO: begin
          // Skid entry is always younger than main, so it moves up on release.
          if (release_s) begin
            state_d      = ST_ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
          end else begin
            state_d = ST_TWO;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
`ifdef IF_STAGE_SKID_EN
    in_ready_d = (state_d != ST_TWO);
`endif
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= {PC_W{1'b0}};
      main_instr_q <= NOP_INSTR;
`ifdef IF_STAGE_SKID_EN
      skid_pc_q    <= {PC_W{1'b0}};
      skid_instr_q <= NOP_INSTR;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
`ifdef IF_STAGE_SKID_EN
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage_pipe_reg.sv
// Directed self-checking bench for if_stage_pipe_reg; adapts to IF_STAGE_SKID_EN.
module tb_if_stage_pipe_reg;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        freeze;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] instruction;

  int tests;
  int fails;

  if_stage_pipe_reg #(
    .PC_W     (32),
    .INSTR_W  (32),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .freeze        (freeze),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .pc_in         (pc_in),
    .instruction_in(instruction_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pc            (pc),
    .instruction   (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] p, input logic [31:0] ins);
    in_valid       = 1'b1;
    pc_in          = p;
    instruction_in = ins;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_ins"}, instruction, NOP);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] p, input logic [31:0] ins);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, pc, p);
    chk({tag, "_ins"}, instruction, ins);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = 32'd0; instruction_in = 32'd0;
    #12;
    chk_empty("reset");
    chk("reset_ir", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    step();

    // Streaming: one entry per cycle, visible one edge after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i), 32'hA000_0000 + 32'(i));
      step();
      chk_head("stream", 32'(4 * i), 32'hA000_0000 + 32'(i));
      chk("stream_ir", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk_empty("stream_end");

    // Asynchronous reset mid-stream clears before the next edge.
    offer(32'd16, 32'hB000_0010);
    step();
    chk_head("pre_rst", 32'd16, 32'hB000_0010);
    #2 rst = 1'b0;
    #1;
    chk_empty("async_rst");
    chk("async_rst_ir", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    step();
    chk_empty("post_rst");

    // Backpressure.
    out_ready = 1'b0;
    offer(32'd0, 32'hC000_0000);
    step();
    chk_head("bp0", 32'd0, 32'hC000_0000);
`ifdef IF_STAGE_SKID_EN
    chk("bp_ir1", {31'd0, in_ready}, 32'd1);
    offer(32'd4, 32'hC000_0004);
    step();
    chk_head("bp_skid", 32'd0, 32'hC000_0000);
    chk("bp_ir0", {31'd0, in_ready}, 32'd0);
    offer(32'd8, 32'hC000_0008);
    step();
    chk_head("bp_hold", 32'd0, 32'hC000_0000);
    chk("bp_ir0b", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk_head("drain4", 32'd4, 32'hC000_0004);
    chk("drain_ir", {31'd0, in_ready}, 32'd1);
    step();
    chk_head("drain8", 32'd8, 32'hC000_0008);
`else
    chk("bp_ir0", {31'd0, in_ready}, 32'd0);
    offer(32'd4, 32'hC000_0004);
    step();
    chk_head("bp_hold", 32'd0, 32'hC000_0000);
    out_ready = 1'b1;
    #1;
    chk("bp_ir_comb", {31'd0, in_ready}, 32'd1);
    step();
    chk_head("drain4", 32'd4, 32'hC000_0004);
`endif
    in_valid = 1'b0;
    step();
    chk_empty("drain_end");

    // Flush with an entry offered in the same cycle drops everything.
`ifdef IF_STAGE_SKID_EN
    out_ready = 1'b0;
    offer(32'd20, 32'hD000_0014);
    step();
    offer(32'd24, 32'hD000_0018);
    step();
    chk("fl_two_ir", {31'd0, in_ready}, 32'd0);
`else
    out_ready = 1'b1;
    offer(32'd20, 32'hD000_0014);
    step();
`endif
    offer(32'd28, 32'hD000_001C);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_empty("flush");
    chk("flush_ir", {31'd0, in_ready}, 32'd1);
    step();
    chk_empty("flush_drop");

    // Freeze for three cycles holds the entry and masks both handshakes.
    out_ready = 1'b0;
    offer(32'd40, 32'hE000_0028);
    step();
    freeze = 1'b1;
    out_ready = 1'b1;
    offer(32'd44, 32'hE000_002C);
    #1;
    chk("frz_ir", {31'd0, in_ready}, 32'd0);
    chk("frz_ov", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_ir_c", {31'd0, in_ready}, 32'd0);
      chk("frz_ov_c", {31'd0, out_valid}, 32'd0);
      chk("frz_pc", pc, 32'd40);
      chk("frz_ins", instruction, 32'hE000_0028);
    end
    freeze = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_head("unfrz", 32'd40, 32'hE000_0028);
    step();
    chk_empty("unfrz_rel");

    // Flush and freeze together: flush wins.
    out_ready = 1'b0;
    offer(32'd48, 32'hF000_0030);
    step();
    chk_head("ff_load", 32'd48, 32'hF000_0030);
    flush = 1'b1;
    freeze = 1'b1;
    offer(32'd52, 32'hF000_0034);
    step();
    flush = 1'b0;
    freeze = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_empty("ff");
    chk("ff_ir", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
